sd_block_scheduler: RTL and testbench
=====================================

SD_BLOCK_SCHEDULER -- requirements
Module: sd_block_scheduler

Interface
REQ-001 Parameter BLOCK_BYTES, default 512: bytes expected per SD block read.
REQ-002 Parameter TIMEOUT, default 16'hFFFF: maximum cycles allowed in BUSY per block.
REQ-003 clock  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 req0, req1  in  1 each  requester read request; held high until the matching done pulse.
REQ-006 addr0, addr1  in  32 each  starting block address; sampled at grant.
REQ-007 count0, count1  in  8 each  number of blocks; sampled at grant.
REQ-008 gnt  out  2  one-hot owner of the reader; 2'b00 when idle.
REQ-009 done  out  2  one-cycle completion pulse, per requester.
REQ-010 err  out  1  one-cycle error pulse, coincident with done.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 rd_start  out  1  one-cycle start pulse to the SD block reader.
REQ-013 rd_addr  out  32  block address presented to the reader; stable from ISSUE until the next NEXT.
REQ-014 rd_busy  in  1  reader busy.
REQ-015 fifo_push  in  1  reader byte strobe into the FIFO.
REQ-016 fifo_free  in  13  free byte slots in the downstream FIFO.

Function
REQ-017 States: IDLE, ARB, WAIT_SPACE, ISSUE, BUSY, NEXT, DONE, ERR.
REQ-018 IDLE -> ARB when req0|req1 is high.
REQ-019 Arbitration is round-robin:
- the requester not granted last wins when both requests are high;
- last-grant pointer resets to requester 1, so req0 wins the first tie.
REQ-020 ARB behaviour:
- latches winner, addr and count;
- gnt is asserted from the ARB cycle onward;
- next state is DONE if count==0, else WAIT_SPACE.
REQ-021 WAIT_SPACE -> ISSUE when fifo_free >= BLOCK_BYTES; otherwise holds with no timeout.
REQ-022 ISSUE drives rd_start=1 for exactly one cycle, then goes to BUSY; the byte counter and timeout counter clear on entry to BUSY.
REQ-023 BUSY sets a seen flag when rd_busy=1; the block completes on the first cycle where the seen flag is set and rd_busy=0.
REQ-024 BUSY byte counting:
- counts fifo_push, 11-bit, saturating at 2047;
- fifo_push outside BUSY is ignored.
REQ-025 On block completion:
- byte count == BLOCK_BYTES -> NEXT;
- any other count -> ERR.
REQ-026 BUSY timeout counter reaching TIMEOUT before completion -> ERR.
REQ-027 NEXT decrements the remaining count and increments rd_addr by 1, wrapping 32'hFFFFFFFF to 0; then remaining==0 -> DONE, else WAIT_SPACE.
REQ-028 DONE pulses done[owner] for one cycle, clears gnt, updates the last-grant pointer, and returns to IDLE.
REQ-029 ERR pulses done[owner] and err together for one cycle, clears gnt, updates the pointer, and returns to IDLE; remaining blocks are abandoned.
REQ-030 A requester deasserting req mid-transfer does not abort; the transfer runs to DONE or ERR.
REQ-031 A new request arriving during a transfer waits; it is arbitrated only from IDLE.
REQ-032 Minimum latency is 1 cycle from req to gnt and 3 cycles from req to rd_start, given sufficient fifo_free.

Reset
REQ-033 With reset=0 at a clock edge, all of the following hold in the next cycle, including when reset occurs mid-transfer:
- state is IDLE;
- gnt=00, done=00, err=0, busy=0, rd_start=0, rd_addr=0;
- counters are cleared;
- last-grant pointer is requester 1.
REQ-034 Reset mid-transfer issues no done pulse.

Verification
REQ-035 Single transfer:
- stimulus: req0, addr0=0x100, count0=2, fifo_free=4096, reader returns 512 pushes per block;
- response: rd_start twice with rd_addr 0x100 then 0x101, one done[0] pulse, err=0.
REQ-036 Tie:
- stimulus: req0 and req1 high together from reset, each count=1;
- response: gnt=01 first, then gnt=10, done[0] before done[1].
REQ-037 Backpressure:
- stimulus: fifo_free=511 held for 100 cycles, then 512;
- response: no rd_start while fifo_free=511; rd_start within 2 cycles of fifo_free reaching 512.
REQ-038 Short block:
- stimulus: reader returns 511 pushes then drops rd_busy;
- response: err and done[owner] pulse together; no further rd_start.
REQ-039 Timeout and wrap:
- timeout: TIMEOUT=16 and rd_busy stuck high -> err after 16 BUSY cycles;
- wrap: addr=0xFFFFFFFF, count=2 -> second rd_addr=0.
REQ-040 Zero count and reset:
- count0=0 -> done[0] with no rd_start;
- reset asserted during BUSY -> all outputs at reset values the next cycle and no done pulse.

Source files
------------

// File: rtl/sd_block_scheduler.sv
// sd_block_scheduler: two-requester round-robin scheduler for an SD block reader.
// A granted request is split into single-block reads. Each block waits for room
// in the downstream FIFO, starts the reader, counts the bytes pushed, and is
// checked for the exact byte count and a per-block cycle timeout.
module sd_block_scheduler #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [7:0]  i_count0,
    input  logic [7:0]  i_count1,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_done,
    output logic        o_err,
    output logic        o_busy,
    output logic        o_rd_start,
    output logic [31:0] o_rd_addr,
    input  logic        i_rd_busy,
    input  logic        i_fifo_push,
    input  logic [12:0] i_fifo_free
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WAIT_SPACE,
        S_ISSUE,
        S_BUSY,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [12:0] BLOCK_FREE = 13'(BLOCK_BYTES);
    localparam logic [10:0] BLOCK_CNT  = 11'(BLOCK_BYTES);
    localparam logic [10:0] BYTES_MAX  = 11'h7FF;

    state_t      r_state;
    logic        r_owner;
    logic        r_last;
    logic [7:0]  r_remaining;
    logic [10:0] r_bytes;
    logic [15:0] r_tmo;
    logic        r_seen;
    logic [1:0]  r_gnt;
    logic [1:0]  r_done;
    logic        r_err;
    logic        r_busy;
    logic        r_rd_start;
    logic [31:0] r_rd_addr;

    logic        w_winner;
    logic [1:0]  w_owner_hot;
    logic [10:0] w_bytes_next;
    logic        w_complete;
    logic        w_timeout;

    // Round-robin pick: on a tie the requester that did not own the reader last wins
    always_comb begin
        w_winner = 1'b0;
        if (i_req0 && i_req1) begin
            w_winner = ~r_last;
        end else if (i_req1) begin
            w_winner = 1'b1;
        end
    end

    assign w_owner_hot  = r_owner ? 2'b10 : 2'b01;
    assign w_bytes_next = (i_fifo_push && (r_bytes != BYTES_MAX)) ? (r_bytes + 11'd1) : r_bytes;
    assign w_complete   = r_seen && !i_rd_busy;
    assign w_timeout    = ({1'b0, r_tmo} + 17'd1) >= {1'b0, TIMEOUT};

    // Scheduler FSM with all outputs registered; pulses default low every cycle
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_remaining <= 8'd0;
            r_bytes     <= 11'd0;
            r_tmo       <= 16'd0;
            r_seen      <= 1'b0;
            r_gnt       <= 2'b00;
            r_done      <= 2'b00;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_start  <= 1'b0;
            r_rd_addr   <= 32'd0;
        end else begin
            r_done     <= 2'b00;
            r_err      <= 1'b0;
            r_rd_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_owner     <= w_winner;
                        r_gnt       <= w_winner ? 2'b10 : 2'b01;
                        r_busy      <= 1'b1;
                        r_rd_addr   <= w_winner ? i_addr1 : i_addr0;
                        r_remaining <= w_winner ? i_count1 : i_count0;
                        r_state     <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (r_remaining == 8'd0) begin
                        r_done  <= w_owner_hot;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT_SPACE;
                    end
                end
                S_WAIT_SPACE: begin
                    if (i_fifo_free >= BLOCK_FREE) begin
                        r_rd_start <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_bytes <= 11'd0;
                    r_tmo   <= 16'd0;
                    r_seen  <= 1'b0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    r_bytes <= w_bytes_next;
                    if (i_rd_busy) begin
                        r_seen <= 1'b1;
                    end
                    if (w_complete) begin
                        if (w_bytes_next == BLOCK_CNT) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_done  <= w_owner_hot;
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end else if (w_timeout) begin
                        r_done  <= w_owner_hot;
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                S_NEXT: begin
                    r_remaining <= r_remaining - 8'd1;
                    r_rd_addr   <= r_rd_addr + 32'd1;
                    if (r_remaining == 8'd1) begin
                        r_done  <= w_owner_hot;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT_SPACE;
                    end
                end
                S_DONE, S_ERR: begin
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt      = r_gnt;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_busy     = r_busy;
    assign o_rd_start = r_rd_start;
    assign o_rd_addr  = r_rd_addr;

endmodule

// File: tb/tb_sd_block_scheduler.sv
// Bench for sd_block_scheduler: a vector table for arbitration, hand-written
// corner sequences, and randomized transfers scored against a transaction model.
module tb_sd_block_scheduler;

    localparam int BLOCK = 512;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [1:0] expFirst;
        logic [1:0] expSecond;
        int         expStarts;
    } vecT;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  gnt;
    } startRecT;

    typedef struct packed {
        logic [1:0] done;
        logic       err;
    } doneRecT;

    logic        clock;
    logic        resetN;
    logic        req0;
    logic        req1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [7:0]  count0;
    logic [7:0]  count1;
    logic [12:0] fifoFree;
    logic        readerBusy;
    logic        readerPush;
    logic        forceBusy;
    logic        strayPush;
    logic        rdBusy;
    logic        fifoPush;
    logic        readerEn;
    logic        readerActive;

    logic [1:0]  dGnt, dDone, tGnt, tDone;
    logic        dErr, dBusy, dRdStart, tErr, tBusy, tRdStart;
    logic [31:0] dRdAddr, tRdAddr;

    int          total = 0;
    int          bad = 0;
    int          readerPlan[$];
    startRecT    startQ[$];
    doneRecT     doneQ[$];
    startRecT    expStartQ[$];
    doneRecT     expDoneQ[$];
    vecT         vecs[7];

    assign rdBusy   = readerBusy | forceBusy;
    assign fifoPush = readerPush | strayPush;

    sd_block_scheduler #(.BLOCK_BYTES(BLOCK), .TIMEOUT(16'd600)) uDut (
        .i_clock(clock), .i_reset(resetN),
        .i_req0(req0), .i_req1(req1), .i_addr0(addr0), .i_addr1(addr1),
        .i_count0(count0), .i_count1(count1),
        .o_gnt(dGnt), .o_done(dDone), .o_err(dErr), .o_busy(dBusy),
        .o_rd_start(dRdStart), .o_rd_addr(dRdAddr),
        .i_rd_busy(rdBusy), .i_fifo_push(fifoPush), .i_fifo_free(fifoFree)
    );

    sd_block_scheduler #(.BLOCK_BYTES(BLOCK), .TIMEOUT(16'd16)) uDutT (
        .i_clock(clock), .i_reset(resetN),
        .i_req0(req0), .i_req1(req1), .i_addr0(addr0), .i_addr1(addr1),
        .i_count0(count0), .i_count1(count1),
        .o_gnt(tGnt), .o_done(tDone), .o_err(tErr), .o_busy(tBusy),
        .o_rd_start(tRdStart), .o_rd_addr(tRdAddr),
        .i_rd_busy(rdBusy), .i_fifo_push(fifoPush), .i_fifo_free(fifoFree)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reader model: after each start, raise busy, push the planned byte count, drop busy
    initial begin
        int n;
        readerBusy = 1'b0;
        readerPush = 1'b0;
        readerActive = 1'b0;
        forever begin
            @(negedge clock);
            if (readerEn && dRdStart) begin
                n = (readerPlan.size() > 0) ? readerPlan.pop_front() : BLOCK;
                readerActive = 1'b1;
                @(negedge clock);
                readerBusy = 1'b1;
                for (int i = 0; i < n; i++) begin
                    readerPush = 1'b1;
                    @(negedge clock);
                end
                readerPush = 1'b0;
                if (n == 0) @(negedge clock);
                readerBusy = 1'b0;
                readerActive = 1'b0;
            end
        end
    end

    // Monitor: log every start (address, owner) and every done pulse (owner, err)
    initial begin
        startRecT s;
        doneRecT  d;
        forever begin
            @(negedge clock);
            if (dRdStart) begin
                s.addr = dRdAddr;
                s.gnt  = dGnt;
                startQ.push_back(s);
            end
            if (dDone != 2'b00) begin
                d.done = dDone;
                d.err  = dErr;
                doneQ.push_back(d);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic doneRecT doneAt(input int idx);
        doneRecT d;
        d.done = 2'b11;
        d.err  = 1'b1;
        if (idx < doneQ.size()) d = doneQ[idx];
        return d;
    endfunction

    function automatic logic [31:0] startAddrAt(input int idx);
        logic [31:0] a;
        a = 32'hDEAD_BEEF;
        if (idx < startQ.size()) a = startQ[idx].addr;
        return a;
    endfunction

    task automatic applyStimulus(input logic r0, input logic r1, input logic [31:0] a0,
                                 input logic [31:0] a1, input logic [7:0] c0, input logic [7:0] c1);
        addr0 = a0;
        addr1 = a1;
        count0 = c0;
        count1 = c1;
        req0 = r0;
        req1 = r1;
    endtask

    // Holds requests until each owner's done pulse, releasing fifo space after holdCycles
    task automatic serveRequests(input int expDones, input int holdCycles, input logic [12:0] freeAfter);
        int got;
        got = 0;
        for (int cyc = 0; cyc < 6000 && got < expDones; cyc++) begin
            @(negedge clock);
            if (cyc == holdCycles) fifoFree = freeAfter;
            if (dDone[0]) begin req0 = 1'b0; got++; end
            if (dDone[1]) begin req1 = 1'b0; got++; end
        end
        fifoFree = freeAfter;
        @(negedge clock);
        checkOutput("serve_done_count", 64'(got), 64'(expDones));
    endtask

    task automatic pulseReset();
        @(negedge clock);
        resetN = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
    endtask

    task automatic waitReaderIdle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 800 && !idle; i++) begin
            @(negedge clock);
            if (!readerActive) idle = 1'b1;
        end
        checkOutput("reader_idle", 64'(idle), 64'd1);
    endtask

    initial begin
        int sb, db, doneBefore, k, nServe, o, pick, n, hold;
        int order[2];
        bit seen, failed;
        logic [1:0]  pattern;
        logic [31:0] ra[2];
        logic [7:0]  rc[2];
        int modelLast;
        startRecT sr;
        doneRecT  dr;

        vecs[0] = '{1'b1, 1'b1, 8'd0, 8'd0, 2'b01, 2'b10, 0};
        vecs[1] = '{1'b0, 1'b1, 8'd0, 8'd1, 2'b10, 2'b00, 1};
        vecs[2] = '{1'b1, 1'b1, 8'd1, 8'd0, 2'b01, 2'b10, 1};
        vecs[3] = '{1'b1, 1'b0, 8'd0, 8'd0, 2'b01, 2'b00, 0};
        vecs[4] = '{1'b1, 1'b1, 8'd2, 8'd0, 2'b10, 2'b01, 2};
        vecs[5] = '{1'b0, 1'b1, 8'd0, 8'd0, 2'b10, 2'b00, 0};
        vecs[6] = '{1'b1, 1'b1, 8'd1, 8'd1, 2'b01, 2'b10, 2};

        resetN = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 8'd0, 8'd0);
        fifoFree = 13'd4096;
        readerEn = 1'b1;
        forceBusy = 1'b0;
        strayPush = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_outputs", 64'({dGnt, dDone, dErr, dBusy, dRdStart, dRdAddr}), 64'd0);
        resetN = 1'b1;
        @(negedge clock);

        // Arbitration table; round-robin pointer carries from one record to the next
        for (int i = 0; i < 7; i++) begin
            sb = startQ.size();
            db = doneQ.size();
            applyStimulus(vecs[i].r0, vecs[i].r1, 32'h10, 32'h20, vecs[i].c0, vecs[i].c1);
            serveRequests(int'(vecs[i].r0) + int'(vecs[i].r1), 0, 13'd4096);
            dr = doneAt(db);
            checkOutput($sformatf("vec%0d_first_done", i), 64'({dr.done, dr.err}), 64'({vecs[i].expFirst, 1'b0}));
            if (vecs[i].r0 && vecs[i].r1) begin
                dr = doneAt(db + 1);
                checkOutput($sformatf("vec%0d_second_done", i), 64'({dr.done, dr.err}), 64'({vecs[i].expSecond, 1'b0}));
            end
            checkOutput($sformatf("vec%0d_starts", i), 64'(startQ.size() - sb), 64'(vecs[i].expStarts));
        end

        // Single two-block transfer with minimum latency checks
        sb = startQ.size();
        db = doneQ.size();
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 8'd2, 8'd0);
        @(negedge clock);
        checkOutput("latency_gnt", 64'({dGnt, dBusy}), 64'({2'b01, 1'b1}));
        @(negedge clock);
        checkOutput("latency_no_early_start", 64'(dRdStart), 64'd0);
        @(negedge clock);
        checkOutput("latency_rd_start", 64'({dRdStart, dRdAddr}), 64'({1'b1, 32'h100}));
        serveRequests(1, 0, 13'd4096);
        checkOutput("single_starts", 64'(startQ.size() - sb), 64'd2);
        checkOutput("single_addr0", 64'(startAddrAt(sb)), 64'h100);
        checkOutput("single_addr1", 64'(startAddrAt(sb + 1)), 64'h101);
        dr = doneAt(db);
        checkOutput("single_done", 64'({dr.done, dr.err}), 64'({2'b01, 1'b0}));
        checkOutput("single_done_count", 64'(doneQ.size() - db), 64'd1);

        // Backpressure: stray pushes while waiting for space must not count
        sb = startQ.size();
        db = doneQ.size();
        fifoFree = 13'd511;
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h200, 8'd0, 8'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            strayPush = 1'($urandom_range(0, 1));
        end
        strayPush = 1'b0;
        checkOutput("bp_no_start", 64'(startQ.size() - sb), 64'd0);
        fifoFree = 13'd512;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            if (dRdStart) seen = 1'b1;
        end
        checkOutput("bp_start_after_space", 64'(seen), 64'd1);
        serveRequests(1, 0, 13'd512);
        dr = doneAt(db);
        checkOutput("bp_done", 64'({dr.done, dr.err}), 64'({2'b10, 1'b0}));

        // Short block: 511 bytes ends the transfer with err, remaining block abandoned
        sb = startQ.size();
        db = doneQ.size();
        readerPlan.push_back(511);
        applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 8'd2, 8'd0);
        serveRequests(1, 0, 13'd4096);
        dr = doneAt(db);
        checkOutput("short_err_done", 64'({dr.done, dr.err}), 64'({2'b01, 1'b1}));
        repeat (20) @(negedge clock);
        checkOutput("short_no_more_start", 64'(startQ.size() - sb), 64'd1);

        // Address wrap from the top of the space
        sb = startQ.size();
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 8'd2, 8'd0);
        serveRequests(1, 0, 13'd4096);
        checkOutput("wrap_addr0", 64'(startAddrAt(sb)), 64'hFFFF_FFFF);
        checkOutput("wrap_addr1", 64'(startAddrAt(sb + 1)), 64'h0);

        // Reset during BUSY: outputs clear next cycle, no done pulse, pointer back to 1
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 8'd1, 8'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (dRdStart) seen = 1'b1;
        end
        checkOutput("midreset_started", 64'(seen), 64'd1);
        repeat (50) @(negedge clock);
        doneBefore = doneQ.size();
        resetN = 1'b0;
        @(negedge clock);
        checkOutput("midreset_outputs", 64'({dGnt, dDone, dErr, dBusy, dRdStart, dRdAddr}), 64'd0);
        req0 = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        waitReaderIdle();
        checkOutput("midreset_no_done", 64'(doneQ.size() - doneBefore), 64'd0);
        db = doneQ.size();
        applyStimulus(1'b1, 1'b1, 32'h0, 32'h0, 8'd0, 8'd0);
        serveRequests(2, 0, 13'd4096);
        dr = doneAt(db);
        checkOutput("midreset_pointer", 64'(dr.done), 64'(2'b01));

        // Timeout on the short-timeout instance: busy held forever
        pulseReset();
        readerEn = 1'b0;
        forceBusy = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 8'd1, 8'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (tRdStart) seen = 1'b1;
        end
        checkOutput("tmo_started", 64'({seen, tGnt}), 64'({1'b1, 2'b01}));
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            k++;
            if (tErr) seen = 1'b1;
        end
        checkOutput("tmo_latency", 64'(k), 64'd17);
        checkOutput("tmo_err_done", 64'({tErr, tDone, tBusy, tRdAddr}), 64'({1'b1, 2'b01, 1'b1, 32'h40}));
        checkOutput("tmo_long_instance_quiet", 64'({dErr, dDone}), 64'd0);
        forceBusy = 1'b0;
        readerEn = 1'b1;
        pulseReset();

        // Randomized transfers against a transaction-level model
        modelLast = 1;
        for (int it = 0; it < 12; it++) begin
            sb = startQ.size();
            db = doneQ.size();
            expStartQ.delete();
            expDoneQ.delete();
            readerPlan.delete();
            pattern = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                ra[r] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                rc[r] = 8'($urandom_range(0, 2));
            end
            if (pattern == 2'b11) begin
                order[0] = (modelLast == 1) ? 0 : 1;
                order[1] = 1 - order[0];
                nServe = 2;
            end else begin
                order[0] = (pattern == 2'b01) ? 0 : 1;
                order[1] = 0;
                nServe = 1;
            end
            for (int s = 0; s < nServe; s++) begin
                o = order[s];
                failed = 1'b0;
                for (int b = 0; b < int'(rc[o]) && !failed; b++) begin
                    sr.addr = ra[o] + 32'(b);
                    sr.gnt  = (o == 0) ? 2'b01 : 2'b10;
                    expStartQ.push_back(sr);
                    pick = $urandom_range(0, 9);
                    n = (pick == 0) ? 511 : (pick == 1) ? 513 : (pick == 2) ? 0 : BLOCK;
                    readerPlan.push_back(n);
                    if (n != BLOCK) failed = 1'b1;
                end
                dr.done = (o == 0) ? 2'b01 : 2'b10;
                dr.err  = failed;
                expDoneQ.push_back(dr);
                modelLast = o;
            end
            hold = $urandom_range(0, 15);
            fifoFree = 13'($urandom_range(0, 511));
            applyStimulus(pattern[0], pattern[1], ra[0], ra[1], rc[0], rc[1]);
            serveRequests(nServe, hold, 13'($urandom_range(512, 8191)));
            checkOutput($sformatf("rnd%0d_starts", it), 64'(startQ.size() - sb), 64'(expStartQ.size()));
            for (int j = 0; j < expStartQ.size(); j++) begin
                if (sb + j < startQ.size()) begin
                    checkOutput($sformatf("rnd%0d_start%0d", it, j), 64'(startQ[sb + j]), 64'(expStartQ[j]));
                end
            end
            for (int j = 0; j < expDoneQ.size(); j++) begin
                checkOutput($sformatf("rnd%0d_done%0d", it, j), 64'(doneAt(db + j)), 64'(expDoneQ[j]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
